// File: rtl/vga_timing_pkg.sv
// Shared VGA timing sets and the helper that sums a line/frame total.
package vga_timing_pkg;

  // 640x480 @ 60 Hz, 25.175 MHz pixel clock
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;

  // 800x600 @ 60 Hz, 40 MHz pixel clock
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;

  // Full line length (pixels) or frame length (lines)
  function automatic int unsigned total(input int unsigned a, input int unsigned fp,
                                        input int unsigned s, input int unsigned bp);
    return a + fp + s + bp;
  endfunction

endpackage

// File: rtl/vga_ce_delay.sv
// Enable-gated shift register; flush and reset both load the idle word.
module vga_ce_delay #(
  parameter int unsigned W     = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_ce,
  input  logic         i_flush,
  input  logic [W-1:0] i_idle,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [W-1:0] stage_q [DEPTH];
    logic [W-1:0] stage_d [DEPTH];

    // Next stage contents: flush wins over shift, otherwise hold
    always_comb begin
      for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = stage_q[i];
      if (i_flush) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_d[i] = i_idle;
      end else if (i_ce) begin
        stage_d[0] = i_d;
        for (int unsigned i = 1; i < DEPTH; i++) stage_d[i] = stage_q[i-1];
      end
    end

    // Stage registers, idle after reset
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= i_idle;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= stage_d[i];
      end
    end

    assign o_q = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: h/v counters, decode, frame counter,
// and a pixel-enable delay line (1 + PIPE_LAT stages) feeding the outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CW       = 12,
  parameter int unsigned FRAME_W  = 8,
  parameter int unsigned PIPE_LAT = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_pix_ce,
  input  logic               i_en,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic [CW-1:0]      o_x,
  output logic [CW-1:0]      o_y,
  output logic               o_sof,
  output logic               o_eol,
  output logic [FRAME_W-1:0] o_frame_cnt
);

  localparam int unsigned H_TOT = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOT = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if (((H_TOT >> CW) != 0) || ((V_TOT >> CW) != 0) ||
      (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1) || (PIPE_LAT > 15)) begin : g_param_check
    $error("vga_timing_gen: illegal timing parameters");
  end

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EOL    = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          sof;
    logic          eol;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  localparam pix_t IDLE_PIX = '{hs: ~H_POL, vs: ~V_POL, default: '0};

  logic [CW-1:0]      h_q, h_d, v_q, v_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  pix_t               dec;
  pix_t               out_pix;
  logic               active;

  // Raster counters; i_en low parks them at the origin, frame count is kept
  always_comb begin
    h_d     = h_q;
    v_d     = v_q;
    frame_d = frame_q;
    if (!i_en) begin
      h_d = '0;
      v_d = '0;
    end else if (i_pix_ce) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d     = '0;
          frame_d = frame_q + FRAME_W'(1);
        end else begin
          v_d = v_q + CW'(1);
        end
      end else begin
        h_d = h_q + CW'(1);
      end
    end
  end

  // Counter and frame counter registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
    end
  end

  // Decode the current counter position into the output word
  always_comb begin
    active  = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    dec     = IDLE_PIX;
    dec.hs  = ((h_q >= HS_START) && (h_q < HS_END)) ? H_POL : ~H_POL;
    dec.vs  = ((v_q >= VS_START) && (v_q < VS_END)) ? V_POL : ~V_POL;
    dec.de  = active;
    dec.sof = (h_q == '0) && (v_q == '0);
    dec.eol = active && (h_q == H_EOL);
    dec.x   = active ? h_q : '0;
    dec.y   = active ? v_q : '0;
  end

  // The first stage of this line is the decode register itself, so the
  // whole output path is 1 + PIPE_LAT pixel enables deep.
  vga_ce_delay #(
    .W     ($bits(pix_t)),
    .DEPTH (PIPE_LAT + 1)
  ) u_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_ce    (i_pix_ce),
    .i_flush (~i_en),
    .i_idle  (IDLE_PIX),
    .i_d     (dec),
    .o_q     (out_pix)
  );

  assign o_hsync     = out_pix.hs;
  assign o_vsync     = out_pix.vs;
  assign o_de        = out_pix.de;
  assign o_sof       = out_pix.sof;
  assign o_eol       = out_pix.eol;
  assign o_x         = out_pix.x;
  assign o_y         = out_pix.y;
  assign o_frame_cnt = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances (PIPE_LAT 0 and 3) on shared
// stimulus, a behavioural raster model feeding a scoreboard queue, plus
// directed measurements of line/frame timing.
module tb_vga_timing_gen;

  localparam int unsigned CW = 12;
  localparam int unsigned FW = 2;
  localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int unsigned HT = 16, VT = 8;

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          de;
    logic          sof;
    logic          eol;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
  } pix_t;

  typedef struct packed {
    pix_t          p0;
    pix_t          p3;
    logic [FW-1:0] frame;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, pix_ce, en;

  logic hs0, vs0, de0, sof0, eol0, hs3, vs3, de3, sof3, eol3;
  logic [CW-1:0] x0, y0, x3, y3;
  logic [FW-1:0] fr0, fr3;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CW), .FRAME_W(FW), .PIPE_LAT(0)
  ) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_ce(pix_ce), .i_en(en),
    .o_hsync(hs0), .o_vsync(vs0), .o_de(de0), .o_x(x0), .o_y(y0),
    .o_sof(sof0), .o_eol(eol0), .o_frame_cnt(fr0)
  );

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CW), .FRAME_W(FW), .PIPE_LAT(3)
  ) dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_ce(pix_ce), .i_en(en),
    .o_hsync(hs3), .o_vsync(vs3), .o_de(de3), .o_x(x3), .o_y(y3),
    .o_sof(sof3), .o_eol(eol3), .o_frame_cnt(fr3)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural raster model
  int unsigned   mh, mv;
  logic [FW-1:0] mframe;
  pix_t          mpipe [4];
  exp_t          sb [$];

  function automatic pix_t idle_pix();
    pix_t p;
    p    = '0;
    p.hs = 1'b1;
    p.vs = 1'b1;
    return p;
  endfunction

  function automatic pix_t decode(input int unsigned h, input int unsigned v);
    pix_t p;
    p     = '0;
    p.de  = (h < HA) && (v < VA);
    p.hs  = ((h >= HA + HF) && (h < HA + HF + HS)) ? 1'b0 : 1'b1;
    p.vs  = ((v >= VA + VF) && (v < VA + VF + VS)) ? 1'b0 : 1'b1;
    p.sof = (h == 0) && (v == 0);
    p.eol = p.de && (h == HA - 1);
    p.x   = p.de ? CW'(h) : '0;
    p.y   = p.de ? CW'(v) : '0;
    return p;
  endfunction

  task automatic model_reset();
    mh = 0; mv = 0; mframe = '0;
    for (int i = 0; i < 4; i++) mpipe[i] = idle_pix();
  endtask

  task automatic model_clock();
    if (!en) begin
      mh = 0; mv = 0;
      for (int i = 0; i < 4; i++) mpipe[i] = idle_pix();
    end else if (pix_ce) begin
      for (int i = 3; i > 0; i--) mpipe[i] = mpipe[i-1];
      mpipe[0] = decode(mh, mv);
      if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          mframe = mframe + 1'b1;
        end else mv = mv + 1;
      end else mh = mh + 1;
    end
  endtask

  // Directed-measurement statistics taken from the PIPE_LAT=0 instance
  int unsigned cyc, de_clk, eol_clk, hs_lo, vs_lo, first_hs_cyc;
  int unsigned last_eol_rise, eol_period, eol_x, x_steps;
  logic prev_eol, prev_de;
  logic [CW-1:0] prev_x;

  task automatic clear_stats();
    de_clk = 0; eol_clk = 0; hs_lo = 0; vs_lo = 0; first_hs_cyc = 0;
    last_eol_rise = 0; eol_period = 0; eol_x = 0; x_steps = 0;
    prev_eol = 1'b0; prev_de = 1'b0; prev_x = '0;
  endtask

  // One clock: model on the rising edge, compare on the falling edge
  task automatic cycle();
    exp_t e;
    pix_t got0, got3;
    @(posedge clk);
    if (rst_n) model_clock();
    else model_reset();
    e.p0 = mpipe[0];
    e.p3 = mpipe[3];
    e.frame = mframe;
    sb.push_back(e);
    @(negedge clk);
    cyc++;
    got0 = '{hs: hs0, vs: vs0, de: de0, sof: sof0, eol: eol0, x: x0, y: y0};
    got3 = '{hs: hs3, vs: vs3, de: de3, sof: sof3, eol: eol3, x: x3, y: y3};
    if (sb.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check("out_lat0", got0, e.p0);
      check("out_lat3", got3, e.p3);
      check("frame_lat0", fr0, e.frame);
      check("frame_lat3", fr3, e.frame);
    end
    if (de0) de_clk++;
    if (eol0) begin eol_clk++; eol_x = x0; end
    if (!hs0) begin hs_lo++; if (first_hs_cyc == 0) first_hs_cyc = cyc; end
    if (!vs0) vs_lo++;
    if (eol0 && !prev_eol) begin
      if (last_eol_rise != 0) eol_period = cyc - last_eol_rise;
      last_eol_rise = cyc;
    end
    if (de0 && (!prev_de || x0 != prev_x)) x_steps++;
    prev_eol = eol0; prev_de = de0; prev_x = x0;
  endtask

  initial begin
    pix_t idle_v;
    logic [FW-1:0] saved_frame;
    logic found;
    idle_v = idle_pix();
    rst_n = 1'b0; en = 1'b1; pix_ce = 1'b1;
    model_reset();
    clear_stats();
    cyc = 0;

    // T1: reset values, then first enable after release shows origin
    repeat (3) cycle();
    check("rst_hsync", hs0, 1'b1);
    check("rst_vsync", vs0, 1'b1);
    check("rst_de", de0, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    clear_stats();
    cycle();
    check("t1_sof", sof0, 1'b1);
    check("t1_de", de0, 1'b1);
    check("t1_x", x0, 0);
    check("t1_y", y0, 0);

    // T2: one line
    while (cyc < 16) cycle();
    check("t2_de_clocks", de_clk, 8);
    check("t2_eol_count", eol_clk, 1);
    check("t2_eol_x", eol_x, 7);
    check("t2_hsync_low", hs_lo, 3);
    check("t2_hsync_first_h", first_hs_cyc - 1, 10);
    while (cyc < 32) cycle();
    check("t2_line_period", eol_period, 16);

    // T3: frame length, vsync width, frame counter wrap
    while (cyc < 127) cycle();
    check("t3_frame_before", fr0, 0);
    cycle();
    check("t3_frame_after", fr0, 1);
    check("t3_vsync_low", vs_lo, 32);
    while (cyc < 511) cycle();
    check("t3_frame_3", fr0, 3);
    cycle();
    check("t3_frame_wrap", fr0, 0);

    // T4: pixel enable at half rate
    clear_stats();
    for (int i = 0; i < 64; i++) begin
      pix_ce = (i % 2 == 0);
      cycle();
    end
    pix_ce = 1'b1;
    check("t4_line_period", eol_period, 32);
    check("t4_de_clocks", de_clk, 32);
    check("t4_eol_clocks", eol_clk, 4);
    check("t4_x_steps", x_steps, 16);

    // T5: drop i_en mid-frame at (5,2)
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      cycle();
      if (de0 && x0 == 5 && y0 == 2) found = 1'b1;
    end
    check("t5_find_5_2", found, 1'b1);
    saved_frame = fr0;
    en = 1'b0;
    cycle();
    check("t5_idle_de", de0, 1'b0);
    check("t5_idle_x", x0, 0);
    check("t5_idle_hs", hs0, 1'b1);
    cycle();
    cycle();
    check("t5_frame_held", fr0, saved_frame);
    en = 1'b1;
    cycle();
    check("t5_restart_sof", sof0, 1'b1);
    check("t5_restart_de", de0, 1'b1);
    check("t5_restart_sof3_early", sof3, 1'b0);
    repeat (3) cycle();
    check("t6_sof3_delayed", sof3, 1'b1);

    // T6: asynchronous reset pulse mid-line
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      cycle();
      if (de0 && x0 == 3) found = 1'b1;
    end
    check("t6_find_x3", found, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_out0", {hs0, vs0, de0, sof0, eol0, x0, y0}, idle_v);
    check("t6_rst_out3", {hs3, vs3, de3, sof3, eol3, x3, y3}, idle_v);
    check("t6_rst_frame", fr0, 0);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (40) cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
